// File: rtl/mvb_merge_lanes_if.sv
// MVB bus bundle: data, per-item valid and the source/destination ready pair.
// RDY_WIDTH lets one definition cover both the per-lane RX side (one ready
// pair per lane) and the single-word TX side (one ready pair for the word).
interface mvb_merge_lanes_if #(
    parameter int ITEMS      = 4,
    parameter int ITEM_WIDTH = 8,
    parameter int RDY_WIDTH  = 1
) ();

    logic [ITEMS*ITEM_WIDTH-1:0] data;
    logic [ITEMS-1:0]            vld;
    logic [RDY_WIDTH-1:0]        src_rdy;
    logic [RDY_WIDTH-1:0]        dst_rdy;

    // Producer side of the bus.
    modport master (
        output data,
        output vld,
        output src_rdy,
        input  dst_rdy
    );

    // Consumer side of the bus.
    modport slave (
        input  data,
        input  vld,
        input  src_rdy,
        output dst_rdy
    );

endinterface : mvb_merge_lanes_if

// File: rtl/mvb_merge_lanes.sv
// mvb_merge_lanes: gathers ITEMS single-item MVB lanes into one ITEMS-wide
// MVB word. Lane i always lands in output slot i. Every lane owns a 2-entry
// FIFO so that its ready can be registered, and the output word is a
// register fed only from buffered state, so no combinational path runs
// from TX_DST_RDY to any RX_DST_RDY.
module mvb_merge_lanes #(
    parameter int ITEMS      = 4,
    parameter int ITEM_WIDTH = 8,
    parameter int WAIT_ALL   = 0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    mvb_merge_lanes_if.slave     RX,
    mvb_merge_lanes_if.master    TX
);

    typedef logic [ITEM_WIDTH-1:0] item_t;

    // Lane FIFO storage: ent0 is always the head, ent1 the second entry.
    item_t              ent0_q [ITEMS];
    item_t              ent0_d [ITEMS];
    item_t              ent1_q [ITEMS];
    item_t              ent1_d [ITEMS];
    logic [1:0]         occ_q  [ITEMS];
    logic [1:0]         occ_d  [ITEMS];
    logic [ITEMS-1:0]   rx_rdy_q;
    logic [ITEMS-1:0]   rx_rdy_d;

    // Output word register.
    logic [ITEMS*ITEM_WIDTH-1:0] tx_data_q;
    logic [ITEMS*ITEM_WIDTH-1:0] tx_data_d;
    logic [ITEMS-1:0]            tx_vld_q;
    logic [ITEMS-1:0]            tx_vld_d;
    logic                        tx_src_rdy_q;
    logic                        tx_src_rdy_d;

    // Per-cycle control.
    logic [ITEMS-1:0]   push_s;
    logic [ITEMS-1:0]   pop_s;
    logic [ITEMS-1:0]   avail_s;
    logic               load_s;
    logic               emit_s;

    // Decode lane pushes and which lanes hold a buffered item this cycle.
    always_comb begin
        push_s  = '0;
        avail_s = '0;
        for (int i = 0; i < ITEMS; i++) begin
            // A handshake with vld low is consumed but never stored.
            push_s[i]  = RX.src_rdy[i] & rx_rdy_q[i] & RX.vld[i];
            // Only registered occupancy counts: an item arriving this cycle
            // cannot reach TX before the next edge.
            avail_s[i] = (occ_q[i] != 2'd0);
        end
    end

    // Decide whether the output register loads, what it loads, and which lanes pop.
    always_comb begin
        tx_data_d    = tx_data_q;
        tx_vld_d     = tx_vld_q;
        tx_src_rdy_d = tx_src_rdy_q;
        pop_s        = '0;

        // The register may take a new word when it is empty or being drained.
        load_s = ~tx_src_rdy_q | TX.dst_rdy[0];

        if (WAIT_ALL != 0) begin
            emit_s = &avail_s;
        end else begin
            emit_s = |avail_s;
        end

        if (load_s) begin
            if (emit_s) begin
                // In lockstep mode emit_s implies avail_s is all ones, so the
                // same assignments give TX_VLD=all ones and pop every lane.
                tx_src_rdy_d = 1'b1;
                tx_vld_d     = avail_s;
                pop_s        = avail_s;
                for (int i = 0; i < ITEMS; i++) begin
                    if (avail_s[i]) begin
                        tx_data_d[i*ITEM_WIDTH +: ITEM_WIDTH] = ent0_q[i];
                    end else begin
                        tx_data_d[i*ITEM_WIDTH +: ITEM_WIDTH] = tx_data_q[i*ITEM_WIDTH +: ITEM_WIDTH];
                    end
                end
            end else begin
                // Nothing to send: drop the word so TX_VLD is never all-zero
                // while TX_SRC_RDY is high.
                tx_src_rdy_d = 1'b0;
                tx_vld_d     = '0;
            end
        end else begin
            // Downstream stalled on a presented word: hold it untouched.
            tx_src_rdy_d = tx_src_rdy_q;
            tx_vld_d     = tx_vld_q;
        end
    end

    // Update each lane FIFO from its push/pop pair and register its ready.
    always_comb begin
        for (int i = 0; i < ITEMS; i++) begin
            ent0_d[i] = ent0_q[i];
            ent1_d[i] = ent1_q[i];
            occ_d[i]  = occ_q[i];

            case ({push_s[i], pop_s[i]})
                2'b10: begin
                    // Push only: fill the first free entry.
                    if (occ_q[i] == 2'd0) begin
                        ent0_d[i] = RX.data[i*ITEM_WIDTH +: ITEM_WIDTH];
                    end else begin
                        ent1_d[i] = RX.data[i*ITEM_WIDTH +: ITEM_WIDTH];
                    end
                    occ_d[i] = occ_q[i] + 2'd1;
                end
                2'b01: begin
                    // Pop only: advance the second entry to the head.
                    ent0_d[i] = ent1_q[i];
                    occ_d[i]  = occ_q[i] - 2'd1;
                end
                2'b11: begin
                    // Push and pop together: occupancy unchanged, FIFO order kept.
                    if (occ_q[i] == 2'd1) begin
                        ent0_d[i] = RX.data[i*ITEM_WIDTH +: ITEM_WIDTH];
                    end else begin
                        ent0_d[i] = ent1_q[i];
                        ent1_d[i] = RX.data[i*ITEM_WIDTH +: ITEM_WIDTH];
                    end
                    occ_d[i] = occ_q[i];
                end
                default: begin
                    occ_d[i] = occ_q[i];
                end
            endcase

            // Ready is registered, so it reflects room after this cycle's update.
            rx_rdy_d[i] = (occ_d[i] < 2'd2);
        end
    end

    // State registers with synchronous reset; buffered and output items are discarded.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < ITEMS; i++) begin
                ent0_q[i] <= '0;
                ent1_q[i] <= '0;
                occ_q[i]  <= 2'd0;
            end
            rx_rdy_q     <= '0;
            tx_data_q    <= '0;
            tx_vld_q     <= '0;
            tx_src_rdy_q <= 1'b0;
        end else begin
            for (int i = 0; i < ITEMS; i++) begin
                ent0_q[i] <= ent0_d[i];
                ent1_q[i] <= ent1_d[i];
                occ_q[i]  <= occ_d[i];
            end
            rx_rdy_q     <= rx_rdy_d;
            tx_data_q    <= tx_data_d;
            tx_vld_q     <= tx_vld_d;
            tx_src_rdy_q <= tx_src_rdy_d;
        end
    end

    assign RX.dst_rdy    = rx_rdy_q;
    assign TX.data       = tx_data_q;
    assign TX.vld        = tx_vld_q;
    assign TX.src_rdy[0] = tx_src_rdy_q;

    mvb_merge_lanes_chk #(
        .ITEMS      (ITEMS),
        .ITEM_WIDTH (ITEM_WIDTH),
        .WAIT_ALL   (WAIT_ALL)
    ) u_chk (
        .clk        (CLK),
        .rst        (RESET),
        .tx_data    (tx_data_q),
        .tx_vld     (tx_vld_q),
        .tx_src_rdy (tx_src_rdy_q),
        .tx_dst_rdy (TX.dst_rdy[0])
    );

endmodule : mvb_merge_lanes

// Output-side protocol properties of the merged stream.
module mvb_merge_lanes_chk #(
    parameter int ITEMS      = 4,
    parameter int ITEM_WIDTH = 8,
    parameter int WAIT_ALL   = 0
) (
    input logic                        clk,
    input logic                        rst,
    input logic [ITEMS*ITEM_WIDTH-1:0] tx_data,
    input logic [ITEMS-1:0]            tx_vld,
    input logic                        tx_src_rdy,
    input logic                        tx_dst_rdy
);

    // A presented word always carries at least one item.
    a_vld_nonzero : assert property (@(posedge clk) disable iff (rst)
        tx_src_rdy |-> (tx_vld != '0));

    // A stalled word stays exactly as it was until it is taken.
    a_hold_stable : assert property (@(posedge clk) disable iff (rst)
        (tx_src_rdy && !tx_dst_rdy) |=> (tx_src_rdy && $stable(tx_vld) && $stable(tx_data)));

    // In lockstep mode every presented word is full.
    a_lockstep_full : assert property (@(posedge clk) disable iff (rst)
        ((WAIT_ALL != 0) && tx_src_rdy) |-> (tx_vld == {ITEMS{1'b1}}));

endmodule : mvb_merge_lanes_chk

// File: tb/tb_mvb_merge_lanes.sv
// Bench for mvb_merge_lanes: one instance with WAIT_ALL=0 and one with
// WAIT_ALL=1 share the same stimulus. A per-lane queue model predicts
// both every cycle; literal checks pin the headline scenarios.
module tb_mvb_merge_lanes;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [N*W-1:0]   drv_data;
    logic [N-1:0]     drv_vld;
    logic [N-1:0]     drv_src;
    logic             drv_txrdy;

    mvb_merge_lanes_if #(.ITEMS(N), .ITEM_WIDTH(W), .RDY_WIDTH(N)) rx0 ();
    mvb_merge_lanes_if #(.ITEMS(N), .ITEM_WIDTH(W), .RDY_WIDTH(N)) rx1 ();
    mvb_merge_lanes_if #(.ITEMS(N), .ITEM_WIDTH(W), .RDY_WIDTH(1)) tx0 ();
    mvb_merge_lanes_if #(.ITEMS(N), .ITEM_WIDTH(W), .RDY_WIDTH(1)) tx1 ();

    assign rx0.data    = drv_data;
    assign rx0.vld     = drv_vld;
    assign rx0.src_rdy = drv_src;
    assign rx1.data    = drv_data;
    assign rx1.vld     = drv_vld;
    assign rx1.src_rdy = drv_src;
    assign tx0.dst_rdy = drv_txrdy;
    assign tx1.dst_rdy = drv_txrdy;

    mvb_merge_lanes #(.ITEMS(N), .ITEM_WIDTH(W), .WAIT_ALL(0)) dut0 (
        .CLK(clk), .RESET(rst), .RX(rx0), .TX(tx0));
    mvb_merge_lanes #(.ITEMS(N), .ITEM_WIDTH(W), .WAIT_ALL(1)) dut1 (
        .CLK(clk), .RESET(rst), .RX(rx1), .TX(tx1));

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // Model state, index 0 = any-lane mode, 1 = lockstep mode.
    logic [W-1:0] m_buf [2][N][2];
    int           m_cnt [2][N];
    logic [N-1:0] m_rdy [2];
    logic         m_src [2];
    logic [N-1:0] m_vld [2];
    logic [W-1:0] m_out [2][N];

    // Accepted words {vld, data} as seen on each DUT's TX.
    logic [N+N*W-1:0] log0 [$];
    logic [N+N*W-1:0] log1 [$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // One clock edge of the behavioural model for both modes.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int i = 0; i < N; i++) m_cnt[d][i] = 0;
                m_rdy[d] = '0;
                m_src[d] = 1'b0;
                m_vld[d] = '0;
            end else begin
                logic load;
                logic emit;
                logic [N-1:0] has;
                load = !m_src[d] || drv_txrdy;
                for (int i = 0; i < N; i++) has[i] = (m_cnt[d][i] > 0);
                emit = (d == 1) ? (has == {N{1'b1}}) : (has != '0);
                if (load) begin
                    if (emit) begin
                        m_src[d] = 1'b1;
                        m_vld[d] = has;
                        for (int i = 0; i < N; i++) begin
                            if (has[i]) begin
                                m_out[d][i]    = m_buf[d][i][0];
                                m_buf[d][i][0] = m_buf[d][i][1];
                                m_cnt[d][i]    = m_cnt[d][i] - 1;
                            end
                        end
                    end else begin
                        m_src[d] = 1'b0;
                        m_vld[d] = '0;
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (drv_src[i] && m_rdy[d][i] && drv_vld[i]) begin
                        m_buf[d][i][m_cnt[d][i]] = drv_data[i*W +: W];
                        m_cnt[d][i] = m_cnt[d][i] + 1;
                    end
                    m_rdy[d][i] = (m_cnt[d][i] < 2);
                end
            end
        end
    endtask

    task automatic cmp(input int d, input logic [N-1:0] rdy, input logic src,
                       input logic [N-1:0] vld, input logic [N*W-1:0] data);
        checks++;
        if (rdy !== m_rdy[d]) begin
            errors++;
            $display("FAIL rx_dst_rdy dut%0d at %0t: got %b expected %b", d, $time, rdy, m_rdy[d]);
        end
        checks++;
        if (src !== m_src[d]) begin
            errors++;
            $display("FAIL tx_src_rdy dut%0d at %0t: got %b expected %b", d, $time, src, m_src[d]);
        end
        if (m_src[d]) begin
            checks++;
            if (vld !== m_vld[d]) begin
                errors++;
                $display("FAIL tx_vld dut%0d at %0t: got %b expected %b", d, $time, vld, m_vld[d]);
            end
            for (int i = 0; i < N; i++) begin
                if (m_vld[d][i]) begin
                    checks++;
                    if (data[i*W +: W] !== m_out[d][i]) begin
                        errors++;
                        $display("FAIL tx_data dut%0d slot%0d at %0t: got %h expected %h",
                                 d, i, $time, data[i*W +: W], m_out[d][i]);
                    end
                end
            end
        end
    endtask

    // Compare both DUTs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                cmp(0, rx0.dst_rdy, tx0.src_rdy[0], tx0.vld, tx0.data);
                cmp(1, rx1.dst_rdy, tx1.src_rdy[0], tx1.vld, tx1.data);
            end
        end
    end

    // Apply one cycle of inputs; log words accepted at the coming edge.
    task automatic cyc(input logic [N-1:0] s, input logic [N-1:0] v,
                       input logic [N*W-1:0] dt, input logic tr, input logic r);
        drv_src   = s;
        drv_vld   = v;
        drv_data  = dt;
        drv_txrdy = tr;
        rst       = r;
        #1;
        if (tx0.src_rdy[0] === 1'b1 && drv_txrdy) log0.push_back({tx0.vld, tx0.data});
        if (tx1.src_rdy[0] === 1'b1 && drv_txrdy) log1.push_back({tx1.vld, tx1.data});
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic tr);
        for (int k = 0; k < n; k++) cyc('0, '0, '0, tr, 1'b0);
    endtask

    task automatic do_reset(input logic tr);
        cyc('0, '0, '0, tr, 1'b1);
        cyc('0, '0, '0, tr, 1'b0);
    endtask

    int n0;
    int n1;
    logic [W-1:0] b;

    initial begin
        rst = 1'b1; drv_src = '0; drv_vld = '0; drv_data = '0; drv_txrdy = 1'b1;
        @(negedge clk); #1;
        cyc('0, '0, '0, 1'b1, 1'b1);
        chk_en = 1'b1;
        cyc('0, '0, '0, 1'b1, 1'b1);
        chk("reset_rx_dst_rdy", 64'(rx0.dst_rdy), 64'h0);
        chk("reset_tx_src_rdy", 64'(tx0.src_rdy), 64'h0);
        chk("reset_tx_vld",     64'(tx0.vld),     64'h0);
        cyc('0, '0, '0, 1'b1, 1'b0);
        chk("rdy_after_reset",  64'(rx0.dst_rdy), 64'hF);

        // 1: lane 2 alone sends 0x5A.
        n0 = log0.size();
        cyc(4'b0100, 4'b0100, 32'h005A_0000, 1'b1, 1'b0);
        chk("t1_no_bypass", 64'(tx0.src_rdy), 64'h0);
        cyc('0, '0, '0, 1'b1, 1'b0);
        chk("t1_src_rdy", 64'(tx0.src_rdy), 64'h1);
        chk("t1_vld",     64'(tx0.vld),     64'h4);
        chk("t1_slot2",   64'(tx0.data[23:16]), 64'h5A);
        idle(4, 1'b1);
        chk("t1_words", 64'(log0.size() - n0), 64'd1);

        // 2: all lanes stream 0..99.
        do_reset(1'b1);
        n0 = log0.size();
        for (int n = 0; n < 100; n++) begin
            b = 8'(n);
            cyc(4'hF, 4'hF, {b, b, b, b}, 1'b1, 1'b0);
            chk("t2_rdy", 64'(rx0.dst_rdy), 64'hF);
        end
        idle(3, 1'b1);
        chk("t2_words", 64'(log0.size() - n0), 64'd100);
        for (int n = 0; n < 100; n++) begin
            b = 8'(n);
            if (n0 + n < log0.size()) chk("t2_word", 64'(log0[n0 + n]), 64'({4'hF, b, b, b, b}));
        end

        // 3: backpressure with every lane pushing.
        do_reset(1'b0);
        n0 = log0.size();
        cyc(4'hF, 4'hF, 32'hA0A0_A0A0, 1'b0, 1'b0);
        cyc(4'hF, 4'hF, 32'hA1A1_A1A1, 1'b0, 1'b0);
        cyc(4'hF, 4'hF, 32'hA2A2_A2A2, 1'b0, 1'b0);
        chk("t3_rdy_low", 64'(rx0.dst_rdy), 64'h0);
        cyc(4'hF, 4'hF, 32'hA3A3_A3A3, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("t3_hold_src",  64'(tx0.src_rdy), 64'h1);
        chk("t3_hold_data", 64'(tx0.data),    64'hA0A0_A0A0);
        idle(5, 1'b1);
        chk("t3_words", 64'(log0.size() - n0), 64'd3);
        if (log0.size() >= n0 + 3) begin
            chk("t3_w0", 64'(log0[n0]),     64'hF_A0A0A0A0);
            chk("t3_w1", 64'(log0[n0 + 1]), 64'hF_A1A1A1A1);
            chk("t3_w2", 64'(log0[n0 + 2]), 64'hF_A2A2A2A2);
        end

        // 4: lockstep; lane 0 early, lanes 1-3 five cycles later.
        do_reset(1'b1);
        n0 = log0.size();
        n1 = log1.size();
        cyc(4'b0001, 4'b0001, 32'h0000_0011, 1'b1, 1'b0);
        idle(4, 1'b1);
        chk("t4_nothing_early", 64'(tx1.src_rdy), 64'h0);
        cyc(4'b1110, 4'b1110, 32'h4433_2200, 1'b1, 1'b0);
        chk("t4_no_bypass", 64'(tx1.src_rdy), 64'h0);
        cyc('0, '0, '0, 1'b1, 1'b0);
        chk("t4_vld",  64'(tx1.vld),  64'hF);
        chk("t4_data", 64'(tx1.data), 64'h4433_2211);
        idle(3, 1'b1);
        chk("t4_words_lockstep", 64'(log1.size() - n1), 64'd1);
        chk("t4_words_any",      64'(log0.size() - n0), 64'd2);

        // 5: lane 1 transfers with vld low are dropped.
        do_reset(1'b1);
        n0 = log0.size();
        n1 = log1.size();
        for (int k = 0; k < 10; k++) cyc(4'b0010, 4'b0000, 32'h0000_7700, 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("t5_words", 64'(log0.size() - n0), 64'd0);
        chk("t5_rdy",   64'(rx0.dst_rdy),      64'hF);

        // 6: reset with full lanes and a presented word.
        do_reset(1'b0);
        cyc(4'hF, 4'hF, 32'hE0E0_E0E0, 1'b0, 1'b0);
        cyc(4'hF, 4'hF, 32'hE1E1_E1E1, 1'b0, 1'b0);
        cyc(4'hF, 4'hF, 32'hE2E2_E2E2, 1'b0, 1'b0);
        chk("t6_full_src", 64'(tx0.src_rdy), 64'h1);
        n0 = log0.size();
        n1 = log1.size();
        cyc('0, '0, '0, 1'b0, 1'b1);
        chk("t6_rst_src", 64'(tx0.src_rdy), 64'h0);
        chk("t6_rst_rdy", 64'(rx0.dst_rdy), 64'h0);
        cyc('0, '0, '0, 1'b1, 1'b0);
        chk("t6_rdy_back", 64'(rx0.dst_rdy), 64'hF);
        idle(5, 1'b1);
        chk("t6_no_stale0", 64'(log0.size() - n0), 64'd0);
        chk("t6_no_stale1", 64'(log1.size() - n1), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mvb_merge_lanes
